seq_divider: RTL and testbench

Iterative unsigned restoring divider, the inverse of the team's multiplier datapath. It produces one quotient bit per clock over W cycles. Each quotient bit comes from a single W+1-bit trial subtraction, which may be built from the codebase `rca` module with `c_in`=1. Valid/ready handshakes are used on both the operand side and the result side.

---
 rtl/seq_divider.sv | 123 ++++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider.
// It produces one quotient bit per clock over W cycles.
// Operands and results use valid/ready handshakes.
// A result is held stable in DONE until the consumer accepts it.
module seq_divider #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder,
   output logic         div_by_zero
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    q_q, q_d;
   // The partial remainder's top bit is provably 0 after every iteration
   // (R < divisor), so only the low W bits are stored.
   logic [W-1:0]    r_q, r_d;
   logic [W-1:0]    dv_q, dv_d;
   logic            dbz_q, dbz_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;

   logic [W:0]      trial_s;
   logic [W:0]      diff_s;

   // Next-state and datapath: capture in IDLE, one restoring step per BUSY cycle.
   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      r_d         = r_q;
      dv_d        = dv_q;
      dbz_d       = dbz_q;
      cnt_d       = cnt_q;
      trial_s     = {r_q, q_q[W-1]};
      diff_s      = trial_s - {1'b0, dv_q};
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               q_d     = dividend;
               r_d     = {W{1'b0}};
               dv_d    = divisor;
               dbz_d   = (divisor == {W{1'b0}});
               cnt_d   = {CW{1'b0}};
               state_d = BUSY;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (diff_s[W] == 1'b0) begin
               r_d = diff_s[W-1:0];
               q_d = {q_q[W-2:0], 1'b1};
            end else begin
               r_d = trial_s[W-1:0];
               q_d = {q_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end else begin
               state_d = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers; reset clears everything asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         q_q         <= {W{1'b0}};
         r_q         <= {W{1'b0}};
         dv_q        <= {W{1'b0}};
         dbz_q       <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         r_q         <= r_d;
         dv_q        <= dv_d;
         dbz_q       <= dbz_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = (state_q == IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = q_q;
   assign remainder   = r_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=8) with a result scoreboard.
module tb_seq_divider;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   t0     = 0;

   seq_divider #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Watchdog: the bench must never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      res_t e;
      if (b == 8'd0) begin
         e.q = 8'hFF; e.r = a; e.dbz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one operand handshake (waits for in_ready at a falling edge).
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("start_in_ready", {31'd0, in_ready}, 32'd1);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      sb.push_back(model(a, b));
      @(posedge clk);
      #1;
      t0       = cyc;
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 8'($urandom);
   endtask

   // Compare DUT output against the oldest scoreboard entry.
   task automatic compare_result(input string tag);
      res_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_q"},   {24'd0, quotient},  {24'd0, e.q});
         check({tag, "_r"},   {24'd0, remainder}, {24'd0, e.r});
         check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      end
   endtask

   // Wait for out_valid with out_ready high, check latency and in_ready, accept.
   task automatic get_result(input string tag);
      int  n;
      bit  busy_ok;
      out_ready = 1'b1;
      busy_ok   = 1'b1;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 40) begin
         if (in_ready !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_latency"}, cyc - t0, W);
      check({tag, "_busy_in_ready0"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_done_in_ready0"}, {31'd0, in_ready}, 32'd0);
      compare_result(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      res_t e;
      logic [W-1:0] ba [3];
      logic [W-1:0] bb [3];
      int idx, got, last, n;
      bit upd;

      // Reset state, with a handshake attempted during reset.
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      dividend = 8'd77; divisor = 8'd3;
      repeat (3) @(posedge clk);
      #2;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_q", {24'd0, quotient}, 32'd0);
      check("rst_r", {24'd0, remainder}, 32'd0);
      check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

      // Directed operands, including boundaries and divide by zero.
      start_op(8'd100, 8'd7);  get_result("d100_7");
      start_op(8'd255, 8'd1);  get_result("d255_1");
      start_op(8'd3,   8'd200); get_result("d3_200");
      start_op(8'd0,   8'd5);  get_result("d0_5");
      start_op(8'd255, 8'd255); get_result("d255_255");
      start_op(8'd5,   8'd0);  get_result("d5_0");

      // Backpressure: result held 5 cycles, in_valid pulses ignored.
      start_op(8'd200, 8'd9);
      out_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (out_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("bp_latency", cyc - t0, W);
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_q", {24'd0, quotient}, {24'd0, e.q});
         check("bp_hold_r", {24'd0, remainder}, {24'd0, e.r});
         in_valid = (i % 2 == 0);
         dividend = 8'd1; divisor = 8'd1;
         @(negedge clk);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      compare_result("bp");
      @(negedge clk);
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      check("bp_no_capture", sb.size(), 32'd0);

      // Asynchronous reset during the third BUSY cycle.
      start_op(8'd100, 8'd7);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_q", {24'd0, quotient}, 32'd0);
      check("mid_rst_r", {24'd0, remainder}, 32'd0);
      void'(sb.pop_back());
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      start_op(8'd50, 8'd6); get_result("d50_6");

      // Back-to-back stream with in_valid and out_ready held high.
      ba[0] = 8'd17; ba[1] = 8'd64; ba[2] = 8'd13;
      bb[0] = 8'd3;  bb[1] = 8'd8;  bb[2] = 8'd13;
      idx = 0; got = 0; last = 0; upd = 1'b0;
      dividend = ba[0]; divisor = bb[0];
      in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 80 && got < 3; k++) begin
         @(negedge clk);
         if (upd) begin
            upd = 1'b0;
            if (idx < 3) begin
               dividend = ba[idx]; divisor = bb[idx];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (out_valid === 1'b1) begin
            compare_result("b2b");
            if (got > 0) check("b2b_spacing", cyc - last, 32'd10);
            last = cyc;
            got++;
         end
         if (in_ready === 1'b1 && in_valid && idx < 3) begin
            sb.push_back(model(dividend, divisor));
            idx++;
            upd = 1'b1;
         end
      end
      check("b2b_count", got, 32'd3);
      check("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
